// File: rtl/button_pkg.sv
// Shared types and default constants for the push-button digit counter front end.
package button_pkg;

    localparam int DIGIT_W             = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 500000;    // 10 ms at 50 MHz
    localparam int DEF_HOLD_CYCLES     = 50000000;  // 1 s at 50 MHz
    localparam int DEF_MAX_DIGIT       = 9;

    typedef enum logic [2:0] {
        RELEASED     = 3'd0,
        PRESS_WAIT   = 3'd1,
        PRESSED      = 3'd2,
        HELD         = 3'd3,
        RELEASE_WAIT = 3'd4
    } btn_state_e;

    // Width of the shared debounce/hold counter; it only ever reaches max(a, b) - 1.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; both flops reset to RESET_VAL.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_digit_counter.sv
// Debounces an active-low push-button and counts accepted presses into a wrapping digit;
// a long hold clears the digit. All outputs are registered.
module button_digit_counter
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int MAX_DIGIT       = DEF_MAX_DIGIT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               button,
    output logic [DIGIT_W-1:0] digit,
    output logic               press_pulse,
    output logic               clear_pulse,
    output logic               pressed
);

    localparam int                 CNT_W     = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES);
    localparam logic [CNT_W-1:0]   DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [DIGIT_W-1:0] MAX_D     = DIGIT_W'(MAX_DIGIT);

    function automatic logic [DIGIT_W-1:0] next_digit(input logic [DIGIT_W-1:0] d);
        return (d >= MAX_D) ? '0 : d + 1'b1;
    endfunction

    logic               sync_in;
    btn_state_e         state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [DIGIT_W-1:0] digit_nxt;
    logic               press_nxt, clear_nxt, pressed_nxt;

    // Idle level of the pin is high, so the synchroniser resets to "released".
    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (button),
        .q     (sync_in)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RELEASED;
            cnt         <= '0;
            digit       <= '0;
            press_pulse <= 1'b0;
            clear_pulse <= 1'b0;
            pressed     <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            digit       <= digit_nxt;
            press_pulse <= press_nxt;
            clear_pulse <= clear_nxt;
            pressed     <= pressed_nxt;
        end
    end

    // sync_in is active-low: 0 means the button is held down.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        digit_nxt   = digit;
        press_nxt   = 1'b0;
        clear_nxt   = 1'b0;
        pressed_nxt = pressed;
        case (state)
            RELEASED: begin
                if (!sync_in) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (sync_in) begin
                    state_nxt = RELEASED;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt   = PRESSED;
                    cnt_nxt     = '0;
                    press_nxt   = 1'b1;
                    pressed_nxt = 1'b1;
                    digit_nxt   = next_digit(digit);
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (sync_in) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = '0;
                end else if (cnt == HOLD_LAST) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                    clear_nxt = 1'b1;
                    digit_nxt = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HELD: begin
                if (sync_in) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                // A bounce back low parks in HELD so it neither re-counts nor re-clears.
                if (!sync_in) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt   = RELEASED;
                    cnt_nxt     = '0;
                    pressed_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = RELEASED;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_button_digit_counter.sv
// Bench for button_digit_counter: directed scenarios plus random button activity against a run-length model.
module tb_button_digit_counter;

    localparam int DEB  = 4;
    localparam int HOLD = 16;
    localparam int MAXD = 9;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       button = 1'b1;
    logic [3:0] digit;
    logic       press_pulse, clear_pulse, pressed;

    int total = 0;
    int bad   = 0;

    button_digit_counter #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .MAX_DIGIT       (MAXD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .button      (button),
        .digit       (digit),
        .press_pulse (press_pulse),
        .clear_pulse (clear_pulse),
        .pressed     (pressed)
    );

    always #5 clk = ~clk;

    // Reference: delay the pin by two samples, then accept a level once it has been
    // seen DEB+1 samples in a row; a press that stays low HOLD samples clears the digit.
    logic h1, h2, s_m;
    int   m_run, m_hold, m_digit;
    bit   m_deb, m_armed, m_press, m_clear;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1 = 1'b1; h2 = 1'b1;
            m_run = 0; m_hold = 0; m_digit = 0;
            m_deb = 0; m_armed = 0; m_press = 0; m_clear = 0;
        end else begin
            s_m = h2; h2 = h1; h1 = button;
            m_press = 0; m_clear = 0;
            if (!m_deb) begin
                m_run = (s_m == 1'b0) ? m_run + 1 : 0;
                if (m_run == DEB + 1) begin
                    m_deb = 1; m_run = 0; m_press = 1;
                    m_digit = (m_digit + 1) % (MAXD + 1);
                    m_armed = 1; m_hold = 0;
                end
            end else if (s_m == 1'b0) begin
                m_run = 0;
                if (m_armed) begin
                    m_hold++;
                    if (m_hold == HOLD) begin
                        m_clear = 1; m_digit = 0; m_armed = 0;
                    end
                end
            end else begin
                m_armed = 0;
                m_run++;
                if (m_run == DEB + 1) begin
                    m_deb = 0; m_run = 0;
                end
            end
        end
    end

    task automatic tick(input logic b);
        @(negedge clk);
        button = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        button = 1'b1;
        rst_n  = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) tick(1'b0);
        total++;
        if (digit !== 4'd1 || pressed !== 1'b1) begin
            bad++;
            $display("FAIL reset_pre_press: digit=%0d pressed=%0b, need digit=1 pressed=1", digit, pressed);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (digit !== 4'd0 || pressed !== 1'b0 || press_pulse !== 1'b0 || clear_pulse !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: digit=%0d pressed=%0b pp=%0b cp=%0b, need all 0",
                     digit, pressed, press_pulse, clear_pulse);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1);
            total++;
            if (digit !== 4'd0 || pressed !== 1'b0 || press_pulse !== 1'b0 || clear_pulse !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle cyc%0d: digit=%0d pressed=%0b pp=%0b cp=%0b, need all 0",
                         i, digit, pressed, press_pulse, clear_pulse);
            end
        end
    endtask

    task automatic test_clean_press();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            tick((i < 10) ? 1'b0 : 1'b1);
            total++;
            if (press_pulse !== (i == 6) || pressed !== (i >= 6 && i < 16) ||
                digit !== ((i >= 6) ? 4'd1 : 4'd0) || clear_pulse !== 1'b0) begin
                bad++;
                $display("FAIL clean_press edge%0d: pp=%0b pressed=%0b digit=%0d cp=%0b, need pp=%0b pressed=%0b digit=%0d cp=0",
                         i, press_pulse, pressed, digit, clear_pulse,
                         (i == 6), (i >= 6 && i < 16), (i >= 6) ? 1 : 0);
            end
        end
    endtask

    // Runs directly after test_clean_press, which leaves digit at 1.
    task automatic test_bounce();
        logic pat [16];
        for (int i = 0; i < 16; i++) pat[i] = !((i < 3) || (i == 4) || (i == 5));
        for (int i = 0; i < 16; i++) begin
            tick(pat[i]);
            total++;
            if (press_pulse !== 1'b0 || pressed !== 1'b0 || digit !== 4'd1 || clear_pulse !== 1'b0) begin
                bad++;
                $display("FAIL bounce edge%0d: pp=%0b pressed=%0b digit=%0d cp=%0b, need pp=0 pressed=0 digit=1 cp=0",
                         i, press_pulse, pressed, digit, clear_pulse);
            end
        end
    endtask

    task automatic test_wrap();
        int npulse = 0;
        do_reset();
        for (int p = 0; p < 10; p++) begin
            for (int i = 0; i < 20; i++) begin
                tick((i < 8) ? 1'b0 : 1'b1);
                if (press_pulse === 1'b1) npulse++;
                total++;
                if (clear_pulse !== 1'b0) begin
                    bad++;
                    $display("FAIL wrap_noclear press%0d edge%0d: cp=%0b need 0", p, i, clear_pulse);
                end
            end
            total++;
            if (digit !== 4'((p + 1) % 10)) begin
                bad++;
                $display("FAIL wrap_digit press%0d: digit=%0d need %0d", p, digit, (p + 1) % 10);
            end
        end
        total++;
        if (npulse != 10) begin
            bad++;
            $display("FAIL wrap_pulses: count=%0d need 10", npulse);
        end
    endtask

    task automatic test_long_press();
        int press_edge = -1, clear_edge = -1, nclear = 0, npress = 0;
        logic pat [16];
        do_reset();
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < 20; i++) tick((i < 8) ? 1'b0 : 1'b1);
        for (int i = 0; i < 40; i++) begin
            tick(1'b0);
            if (press_pulse === 1'b1) begin
                npress++;
                press_edge = i;
                total++;
                if (digit !== 4'd4) begin
                    bad++;
                    $display("FAIL long_digit_at_press: digit=%0d need 4", digit);
                end
            end
            if (clear_pulse === 1'b1) begin
                nclear++;
                clear_edge = i;
            end
        end
        total++;
        if (npress != 1 || press_edge != 6) begin
            bad++;
            $display("FAIL long_press_edge: count=%0d edge=%0d need count=1 edge=6", npress, press_edge);
        end
        total++;
        if (nclear != 1 || clear_edge - press_edge != HOLD) begin
            bad++;
            $display("FAIL long_clear: count=%0d delay=%0d need count=1 delay=%0d",
                     nclear, clear_edge - press_edge, HOLD);
        end
        total++;
        if (digit !== 4'd0 || pressed !== 1'b1) begin
            bad++;
            $display("FAIL long_after_clear: digit=%0d pressed=%0b need digit=0 pressed=1", digit, pressed);
        end
        for (int i = 0; i < 16; i++) pat[i] = (i != 3);
        for (int i = 0; i < 16; i++) begin
            tick(pat[i]);
            total++;
            if (press_pulse !== 1'b0 || clear_pulse !== 1'b0 || digit !== 4'd0) begin
                bad++;
                $display("FAIL long_release edge%0d: pp=%0b cp=%0b digit=%0d need 0 0 0",
                         i, press_pulse, clear_pulse, digit);
            end
        end
        total++;
        if (pressed !== 1'b0) begin
            bad++;
            $display("FAIL long_released: pressed=%0b need 0", pressed);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 20; i++) tick((i < 8) ? 1'b0 : 1'b1);
        for (int i = 0; i < 5; i++) tick(1'b0);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (digit !== 4'd0 || press_pulse !== 1'b0 || pressed !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: digit=%0d pp=%0b pressed=%0b need 0 0 0", digit, press_pulse, pressed);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (press_pulse !== (i == 6)) begin
                bad++;
                $display("FAIL reset_mid_repress edge%0d: pp=%0b need %0b", i, press_pulse, (i == 6));
            end
        end
        total++;
        if (digit !== 4'd1) begin
            bad++;
            $display("FAIL reset_mid_digit: digit=%0d need 1", digit);
        end
        for (int i = 0; i < 10; i++) tick(1'b1);
    endtask

    task automatic test_random();
        logic lvl;
        int   len;
        do_reset();
        for (int seg = 0; seg < 160; seg++) begin
            lvl = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 40) : $urandom_range(1, 8);
            for (int k = 0; k < len; k++) begin
                tick(lvl);
                total++;
                if (digit !== 4'(m_digit) || press_pulse !== m_press ||
                    clear_pulse !== m_clear || pressed !== m_deb) begin
                    bad++;
                    $display("FAIL random seg%0d: digit=%0d pp=%0b cp=%0b pressed=%0b need digit=%0d pp=%0b cp=%0b pressed=%0b",
                             seg, digit, press_pulse, clear_pulse, pressed, m_digit, m_press, m_clear, m_deb);
                end
                total++;
                if (press_pulse === 1'b1 && clear_pulse === 1'b1) begin
                    bad++;
                    $display("FAIL random_exclusive seg%0d: pp=1 cp=1 need not both", seg);
                end
            end
            if ($urandom_range(0, 30) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                total++;
                if (digit !== 4'd0 || press_pulse !== 1'b0 || clear_pulse !== 1'b0 || pressed !== 1'b0) begin
                    bad++;
                    $display("FAIL random_reset seg%0d: digit=%0d pp=%0b cp=%0b pressed=%0b need all 0",
                             seg, digit, press_pulse, clear_pulse, pressed);
                end
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_wrap();
        test_long_press();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
